pair_queue_arbiter: RTL and testbench

Shares one downstream force pipeline between NQ pair queues, each feeding 227-bit pair entries. Round-robin arbiter: pops at most one entry per cycle from a non-empty queue into a registered valid/ready output stage. A phase FSM tracks one force-evaluation phase from start through queue drain. It reports busy, a one-cycle done pulse and the number of pairs forwarded.

---
 rtl/pair_queue_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pair_queue_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_queue_arbiter.sv
// Round-robin arbiter that drains NQ first-word-fall-through pair queues into one
// registered valid/ready stage, with a phase FSM for start, run, drain and done.
module pair_queue_arbiter #(
    parameter int NQ           = 4,
    parameter int W            = 227,
    parameter int DRAIN_CYCLES = 16,
    parameter int CW           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            src_done,
    input  logic [NQ-1:0]   q_empty,
    input  logic [NQ*W-1:0] q_dout,
    output logic [NQ-1:0]   q_rd_en,
    output logic [W-1:0]    pair_out,
    output logic            pair_valid,
    input  logic            pair_ready,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pair_count
);

    localparam int PW  = $clog2(NQ);
    localparam int PW1 = PW + 1;
    localparam int IW  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [W-1:0]   NULL_PAIR  = {1'b1, {(W-1){1'b0}}};
    localparam logic [IW-1:0]  IDLE_LIMIT = IW'(DRAIN_CYCLES);
    localparam logic [PW1-1:0] NQ_WIDE    = PW1'(NQ);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q,      state_d;
    logic [PW-1:0]   rr_ptr_q,     rr_ptr_d;
    logic            pair_valid_q, pair_valid_d;
    logic [W-1:0]    pair_out_q,   pair_out_d;
    logic [CW-1:0]   pair_count_q, pair_count_d;
    logic            src_done_q,   src_done_d;
    logic [IW-1:0]   idle_cnt_q,   idle_cnt_d;

    logic            active;
    logic            can_load;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW1-1:0]  cand;
    logic            pop;
    logic [W-1:0]    head;

    assign active   = (state_q == RUN) || (state_q == DRAIN);
    assign can_load = active && (!pair_valid_q || pair_ready);

    // First non-empty queue at or after rr_ptr, wrapping modulo NQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NQ; k++) begin
            cand = {1'b0, rr_ptr_q} + PW1'(k);
            if (cand >= NQ_WIDE) begin
                cand = cand - NQ_WIDE;
            end
            if (!grant_found && !q_empty[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    assign pop  = can_load && grant_found && !reset;
    assign head = q_dout[int'(grant_idx) * W +: W];

    always_comb begin
        q_rd_en  = '0;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            q_rd_en[grant_idx] = 1'b1;
            rr_ptr_d = (32'(grant_idx) == NQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // A consumed pair empties the stage; a popped real pair then refills it.
    // Popped null entries only free the queue slot.
    always_comb begin
        pair_valid_d = pair_valid_q;
        pair_out_d   = pair_out_q;
        if (pair_valid_q && pair_ready) begin
            pair_valid_d = 1'b0;
            pair_out_d   = NULL_PAIR;
        end
        if (pop && !head[W-1]) begin
            pair_valid_d = 1'b1;
            pair_out_d   = head;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_done_d   = src_done_q;
        idle_cnt_d   = idle_cnt_q;
        pair_count_d = pair_count_q;
        if (pair_valid_q && pair_ready && (pair_count_q != '1)) begin
            pair_count_d = pair_count_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    src_done_d   = src_done;
                    idle_cnt_d   = '0;
                    pair_count_d = '0;
                end
            end
            RUN: begin
                src_done_d = src_done_q | src_done;
                if (src_done_q || src_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((&q_empty) && !pair_valid_q) begin
                    idle_cnt_d = (idle_cnt_q == IDLE_LIMIT) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end else begin
                    idle_cnt_d = '0;
                end
                if (idle_cnt_d == IDLE_LIMIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            pair_valid_q <= 1'b0;
            pair_out_q   <= NULL_PAIR;
            pair_count_q <= '0;
            src_done_q   <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            pair_valid_q <= pair_valid_d;
            pair_out_q   <= pair_out_d;
            pair_count_q <= pair_count_d;
            src_done_q   <= src_done_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign pair_out   = pair_out_q;
    assign pair_valid = pair_valid_q;
    assign pair_count = pair_count_q;
    assign busy       = active;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_pair_queue_arbiter.sv
// Bench for pair_queue_arbiter: emulated FWFT queues, a cycle reference model
// driven by the round-robin/phase rules, directed scenarios and random phases.
module tb_pair_queue_arbiter;

    localparam int NQ = 4;
    localparam int W  = 227;
    localparam int DC = 16;
    localparam int CW = 32;
    localparam logic [W-1:0] NULLV = {1'b1, {(W-1){1'b0}}};
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic            clk, reset, start, src_done, pair_ready;
    logic [NQ-1:0]   q_empty, q_rd_en;
    logic [NQ*W-1:0] q_dout;
    logic [W-1:0]    pair_out;
    logic            pair_valid, busy, done;
    logic [CW-1:0]   pair_count;

    pair_queue_arbiter #(.NQ(NQ), .W(W), .DRAIN_CYCLES(DC), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .src_done(src_done),
        .q_empty(q_empty), .q_dout(q_dout), .q_rd_en(q_rd_en),
        .pair_out(pair_out), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .busy(busy), .done(done), .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [W-1:0] fifo [NQ][$];
    int grant_log[$];
    logic [W-1:0] dval[$];
    int dcyc[$];
    int cycle = 0, done_cyc = 0, tag_ctr = 0;
    logic saw_done = 1'b0, busy_at_done = 1'b0;

    // reference model state
    int m_phase = P_IDLE, m_ptr = 0, m_idle = 0;
    logic m_pv = 1'b0, m_latch = 1'b0, m_known = 1'b0;
    logic [W-1:0] m_out = NULLV;
    logic [CW-1:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit nul);
        logic [W-1:0] v;
        v = '0;
        tag_ctr++;
        v[31:0]    = tag_ctr;
        v[63:32]   = $urandom();
        v[225:194] = $urandom();
        v[W-1]     = nul;
        return v;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NQ; i++) begin
            q_empty[i] = (fifo[i].size() == 0);
            q_dout[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic tick();
        logic [NQ-1:0] rd, exp_rd;
        int g, nidle;
        logic deliver, idle_c, all_empty;
        logic [W-1:0] hd;
        refresh();
        #2;
        g = -1;
        if (!reset && (m_phase == P_RUN || m_phase == P_DRAIN) && (!m_pv || pair_ready)) begin
            for (int k = 0; k < NQ; k++) begin
                if (g < 0 && fifo[(m_ptr + k) % NQ].size() != 0) g = (m_ptr + k) % NQ;
            end
        end
        exp_rd = '0;
        if (g >= 0) exp_rd[g] = 1'b1;
        if (m_known) begin
            chk("q_rd_en", W'(q_rd_en), W'(exp_rd));
            chk("pair_valid", W'(pair_valid), W'(m_pv));
            chk("pair_out", pair_out, m_out);
            chk("busy", W'(busy), W'(m_phase == P_RUN || m_phase == P_DRAIN));
            chk("done", W'(done), W'(m_phase == P_DONE));
            chk("pair_count", W'(pair_count), W'(m_cnt));
        end
        rd = q_rd_en;
        for (int i = 0; i < NQ; i++) if (rd[i] === 1'b1) grant_log.push_back(i);
        if (pair_valid === 1'b1 && pair_ready) begin
            dval.push_back(pair_out);
            dcyc.push_back(cycle);
        end
        if (done === 1'b1) begin
            saw_done = 1'b1;
            done_cyc = cycle;
            busy_at_done = busy;
        end
        all_empty = 1'b1;
        for (int i = 0; i < NQ; i++) if (fifo[i].size() != 0) all_empty = 1'b0;
        if (reset) begin
            m_phase = P_IDLE; m_ptr = 0; m_pv = 1'b0; m_out = NULLV;
            m_cnt = '0; m_latch = 1'b0; m_idle = 0; m_known = 1'b1;
        end else begin
            deliver = m_pv && pair_ready;
            idle_c  = all_empty && !m_pv;
            if (deliver && m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (deliver) begin m_pv = 1'b0; m_out = NULLV; end
            if (g >= 0) begin
                hd = fifo[g][0];
                m_ptr = (g + 1) % NQ;
                if (!hd[W-1]) begin m_pv = 1'b1; m_out = hd; end
            end
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_RUN; m_latch = src_done; m_idle = 0; m_cnt = '0;
                end
                P_RUN: begin
                    if (m_latch || src_done) m_phase = P_DRAIN;
                    m_latch = m_latch | src_done;
                end
                P_DRAIN: begin
                    nidle = idle_c ? ((m_idle < DC) ? m_idle + 1 : DC) : 0;
                    m_idle = nidle;
                    if (nidle == DC) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (rd[i] === 1'b1 && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
        refresh();
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        dval.delete();
        dcyc.delete();
        saw_done = 1'b0;
    endtask

    task automatic run_to_idle(input int maxc);
        int n;
        n = 0;
        while (!(saw_done && m_phase == P_IDLE) && n < maxc) begin
            tick();
            n++;
        end
        chk("phase_end", W'(saw_done && m_phase == P_IDLE), W'(1));
    endtask

    task automatic finish_phase();
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        run_to_idle(200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[8];
        int n1, di;
        logic [W-1:0] held, rv;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        reset = 1'b1; start = 1'b0; src_done = 1'b0; pair_ready = 1'b0;
        refresh();
        #1;

        // reset state
        do_reset();
        chk("rst_valid", W'(pair_valid), W'(0));
        chk("rst_out", pair_out, NULLV);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_count", W'(pair_count), W'(0));
        chk("rst_rd", W'(q_rd_en), W'(0));

        // three valid pairs from q0, back to back
        clear_logs();
        for (int i = 0; i < 3; i++) fifo[0].push_back(mk(1'b0));
        pair_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("t1_ndeliv", W'(dval.size()), W'(3));
        if (dcyc.size() == 3) chk("t1_consec", W'(dcyc[2] - dcyc[0]), W'(2));
        finish_phase();
        chk("t1_count", W'(pair_count), W'(3));

        // round-robin across four queues from rr_ptr=0
        do_reset();
        clear_logs();
        for (int q = 0; q < NQ; q++) repeat (2) fifo[q].push_back(mk(1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("t2_ngrant", W'(grant_log.size()), W'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) chk("t2_order", W'(grant_log[i]), W'(exp_order[i]));
        end
        if (dcyc.size() == 8) chk("t2_nogap", W'(dcyc[7] - dcyc[0]), W'(7));
        finish_phase();
        chk("t2_count", W'(pair_count), W'(8));

        // backpressure hold for five cycles
        clear_logs();
        for (int i = 0; i < 4; i++) fifo[0].push_back(mk(1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pair_ready = 1'b0;
        held = pair_out;
        chk("t3_valid", W'(pair_valid), W'(1));
        repeat (5) begin
            tick();
            chk("t3_hold_out", pair_out, held);
            chk("t3_hold_rd", W'(q_rd_en), W'(0));
        end
        pair_ready = 1'b1;
        #1;
        chk("t3_resume_rd", W'(q_rd_en), W'(4'b0001));
        repeat (4) tick();
        finish_phase();
        chk("t3_count", W'(pair_count), W'(4));

        // null entry between two valid entries in q1
        clear_logs();
        fifo[1].push_back(mk(1'b0));
        fifo[1].push_back(mk(1'b1));
        fifo[1].push_back(mk(1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n1 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 1) n1++;
        chk("t4_pops", W'(n1), W'(3));
        finish_phase();
        chk("t4_count", W'(pair_count), W'(2));

        // refill q2 mid-drain restarts the idle count
        clear_logs();
        fifo[0].push_back(mk(1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        repeat (10) tick();
        rv = mk(1'b0);
        fifo[2].push_back(rv);
        run_to_idle(100);
        di = -1;
        foreach (dval[j]) if (dval[j] === rv) di = j;
        chk("t5_refill_seen", W'(di >= 0), W'(1));
        if (di >= 0) chk("t5_done_gap", W'(done_cyc - dcyc[di]), W'(17));
        chk("t5_busy_at_done", W'(busy_at_done), W'(0));

        // reset in DRAIN with a held pair
        clear_logs();
        pair_ready = 1'b0;
        fifo[0].push_back(mk(1'b0));
        start = 1'b1;
        src_done = 1'b1;
        tick();
        start = 1'b0;
        src_done = 1'b0;
        repeat (3) tick();
        chk("t6_busy", W'(busy), W'(1));
        chk("t6_valid", W'(pair_valid), W'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_valid", W'(pair_valid), W'(0));
        chk("t6_rst_count", W'(pair_count), W'(0));
        chk("t6_rst_busy", W'(busy), W'(0));
        repeat (20) tick();
        chk("t6_no_done", W'(saw_done), W'(0));

        // start during RUN is ignored
        pair_ready = 1'b1;
        fifo[0].push_back(mk(1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_start_ign_cnt", W'(pair_count), W'(1));
        chk("t6_start_ign_busy", W'(busy), W'(1));
        finish_phase();

        // random phases against the model
        for (int ph = 0; ph < 6; ph++) begin
            int sd_at, n;
            clear_logs();
            for (int q = 0; q < NQ; q++) begin
                repeat ($urandom_range(0, 6)) fifo[q].push_back(mk($urandom_range(0, 4) == 0));
            end
            sd_at = $urandom_range(5, 40);
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!(saw_done && m_phase == P_IDLE) && n < 600) begin
                pair_ready = ($urandom_range(0, 3) != 0);
                src_done = (n >= sd_at) && ($urandom_range(0, 1) == 1);
                if ((m_phase == P_RUN || m_phase == P_DRAIN) && $urandom_range(0, 9) == 0)
                    fifo[$urandom_range(0, NQ - 1)].push_back(mk($urandom_range(0, 4) == 0));
                tick();
                n++;
            end
            src_done = 1'b0;
            chk("rand_phase_end", W'(saw_done && m_phase == P_IDLE), W'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
